// File: rtl/mem_if.sv
// Byte-wide memory-mapped bus shared by the MMU and its bus clients.
// master: drives address/write strobes and samples read data.
// slave:  samples address/write strobes and returns read data.
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: writing 0xFF46 copies 160 bytes from {src, 00..9F} to
// 0xFE00..0xFE9F through the MMU bus-master port. Sources in 0xE0..0xFF
// fold down by 0x20 onto WRAM. While idle the master port parks at 0xFFFF.
module oam_dma_engine #(
    parameter int READ_LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    mem_if.slave   mmio_dma_if,
    mem_if.master  dma_req,
    output logic   busy
);

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] PARK_ADDR    = 16'hFFFF;
    localparam logic [7:0]  OAM_HI       = 8'hFE;
    localparam logic [7:0]  LAST_IDX     = 8'd159;
    localparam logic [1:0]  RD_LAST      = 2'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic [7:0]  data_q, data_d;

    logic [7:0]  eff_hi;
    logic        reg_wr;

    // Register decode, register readback and echo-region source folding.
    always_comb begin
        reg_wr = mmio_dma_if.write_enable && (mmio_dma_if.addr_select == DMA_REG_ADDR);
        mmio_dma_if.read_out = (mmio_dma_if.addr_select == DMA_REG_ADDR) ? src_hi_q : 8'hFF;
        eff_hi = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
    end

    // Bus-master outputs decoded from registered state only.
    always_comb begin
        dma_req.addr_select  = PARK_ADDR;
        dma_req.write_value  = 8'h00;
        dma_req.write_enable = 1'b0;
        busy                 = 1'b0;
        case (state_q)
            READ: begin
                dma_req.addr_select = {eff_hi, idx_q};
                busy                = 1'b1;
            end
            WRITE: begin
                dma_req.addr_select  = {OAM_HI, idx_q};
                dma_req.write_value  = data_q;
                dma_req.write_enable = 1'b1;
                busy                 = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic; a register write overrides the normal transition
    // while the current cycle's bus access still completes as driven.
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        rd_cnt_d = rd_cnt_q;
        data_d   = data_q;
        case (state_q)
            READ: begin
                if (rd_cnt_q == RD_LAST) begin
                    data_d   = dma_req.read_out;
                    rd_cnt_d = '0;
                    state_d  = WRITE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: ;
        endcase
        if (reg_wr) begin
            src_hi_d = mmio_dma_if.write_value;
            idx_d    = '0;
            rd_cnt_d = '0;
            state_d  = READ;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            src_hi_q <= '0;
            idx_q    <= '0;
            rd_cnt_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            rd_cnt_q <= rd_cnt_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: three instances (READ_LATENCY 1, 0, 3) share
// one register port; each has its own latency-delayed source memory.
// A timeline model predicts every cycle's bus outputs from the time since
// the last register write.
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_we = 1'b0;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  reg_wv = 8'h00;

    logic        busy_w   [3];
    logic [15:0] mon_addr [3];
    logic        mon_we   [3];
    logic [7:0]  mon_wv   [3];
    logic [7:0]  mon_rd   [3];

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt   [3];
    int busy_cnt [3];

    // Reference model state
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_start = 0;
    logic [7:0]  m_src = 8'h00;

    always #5 clk = ~clk;

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    function automatic logic [7:0] src_data(logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        mem_if slv_i ();
        mem_if dma_i ();
        logic [15:0] h1, h2, h3;

        assign slv_i.addr_select  = reg_addr;
        assign slv_i.write_value  = reg_wv;
        assign slv_i.write_enable = reg_we;

        always @(posedge clk) begin
            h1 <= dma_i.addr_select;
            h2 <= h1;
            h3 <= h2;
        end

        assign dma_i.read_out = src_data((L == 0) ? dma_i.addr_select :
                                         (L == 1) ? h1 : (L == 2) ? h2 : h3);

        assign mon_addr[g] = dma_i.addr_select;
        assign mon_we[g]   = dma_i.write_enable;
        assign mon_wv[g]   = dma_i.write_value;
        assign mon_rd[g]   = slv_i.read_out;

        oam_dma_engine #(.READ_LATENCY(L)) u_dut (
            .clk         (clk),
            .rst         (rst_n),
            .mmio_dma_if (slv_i),
            .dma_req     (dma_i),
            .busy        (busy_w[g])
        );
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model bookkeeping on the sampling edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_src    = 8'h00;
        end else begin
            cyc++;
            if (reg_we && reg_addr == 16'hFF46) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_src    = reg_wv;
            end
        end
    end

    // Per-cycle comparison of every instance against the timeline model.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            int per, t, b, ph;
            logic [15:0] ea;
            logic [7:0]  ewv, eff, erd;
            logic        ewe, ebusy, bad;
            per   = lat_of(g) + 2;
            t     = cyc - m_start;
            ea    = 16'hFFFF;
            ewe   = 1'b0;
            ewv   = 8'h00;
            ebusy = 1'b0;
            eff   = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
            erd   = (reg_addr == 16'hFF46) ? m_src : 8'hFF;
            if (rst_n && m_active && t >= 0 && t < 160 * per) begin
                b     = t / per;
                ph    = t % per;
                ebusy = 1'b1;
                if (ph <= lat_of(g)) begin
                    ea = {eff, 8'(b)};
                end else begin
                    ea  = 16'hFE00 + 16'(b);
                    ewe = 1'b1;
                    ewv = 8'(b) ^ 8'h5A;
                end
            end
            bad = (mon_addr[g] !== ea) || (mon_we[g] !== ewe) || (busy_w[g] !== ebusy) ||
                  (mon_rd[g] !== erd) || ((!ebusy || ewe) && mon_wv[g] !== ewv);
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL cycle %0d inst %0d: got addr=%h we=%b wv=%h busy=%b rd=%h expected addr=%h we=%b wv=%h busy=%b rd=%h",
                         cyc, g, mon_addr[g], mon_we[g], mon_wv[g], busy_w[g], mon_rd[g],
                         ea, ewe, ewv, ebusy, erd);
            end
            if (mon_we[g] === 1'b1) wr_cnt[g]++;
            if (busy_w[g] === 1'b1) busy_cnt[g]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int g = 0; g < 3; g++) begin
            wr_cnt[g]   = 0;
            busy_cnt[g] = 0;
        end
    endtask

    task automatic reg_write(logic [7:0] v);
        reg_we   = 1'b1;
        reg_addr = 16'hFF46;
        reg_wv   = v;
        step();
        reg_we   = 1'b0;
        reg_addr = 16'h0000;
    endtask

    task automatic check_idle(string name);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_addr%0d", name, g), mon_addr[g], 16'hFFFF);
            chk($sformatf("%s_we%0d", name, g), mon_we[g], 0);
            chk($sformatf("%s_busy%0d", name, g), busy_w[g], 0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wv;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit found;
        tbl[0]  = '{1'b0, 16'hFF46, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 16'hFF46, 8'h80, 8'h00};
        tbl[2]  = '{1'b0, 16'hFF46, 8'h00, 8'h80};
        tbl[3]  = '{1'b0, 16'hFF45, 8'h00, 8'hFF};
        tbl[4]  = '{1'b1, 16'hFF45, 8'h12, 8'hFF};
        tbl[5]  = '{1'b0, 16'hFF46, 8'h00, 8'h80};
        tbl[6]  = '{1'b1, 16'hFF47, 8'h34, 8'hFF};
        tbl[7]  = '{1'b0, 16'hFF46, 8'h00, 8'h80};
        tbl[8]  = '{1'b1, 16'hFF46, 8'hE3, 8'h80};
        tbl[9]  = '{1'b0, 16'hFF46, 8'h00, 8'hE3};
        tbl[10] = '{1'b0, 16'h0000, 8'h00, 8'hFF};
        tbl[11] = '{1'b0, 16'hFE46, 8'h00, 8'hFF};
        clear_counts();

        // Reset state
        #13;
        reg_addr = 16'hFF46;
        #1;
        check_idle("reset");
        for (int g = 0; g < 3; g++) chk($sformatf("reset_rd%0d", g), mon_rd[g], 8'h00);
        rst_n = 1'b1;
        run(3);

        // Register port vectors (the E3 write leaves an echo-fold transfer running)
        for (int i = 0; i < 12; i++) begin
            reg_we   = tbl[i].we;
            reg_addr = tbl[i].addr;
            reg_wv   = tbl[i].wv;
            #1;
            for (int g = 0; g < 3; g++)
                chk($sformatf("tbl%0d_rd%0d", i, g), mon_rd[g], tbl[i].exp_rd);
            step();
        end
        reg_we   = 1'b0;
        reg_addr = 16'h0000;
        run(820);

        // Basic copy from C1 on every latency
        check_idle("pre_copy");
        reg_write(8'hC1);
        clear_counts();
        run(820);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("copy_writes%0d", g), wr_cnt[g], 160);
            chk($sformatf("copy_busy%0d", g), busy_cnt[g], 160 * (lat_of(g) + 2));
        end
        check_idle("post_copy");

        // Top of the echo region folds to DF
        reg_write(8'hFF);
        clear_counts();
        run(820);
        for (int g = 0; g < 3; g++) chk($sformatf("fold_writes%0d", g), wr_cnt[g], 160);

        // Restart during the WRITE of byte 50 (latency-1 instance)
        reg_write(8'hC0);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (mon_we[0] && mon_addr[0] == 16'hFE32) found = 1'b1;
            else step();
        end
        chk("restart_byte50_written", int'(found), 1);
        reg_write(8'hD0);
        chk("restart_first_read", mon_addr[0], 16'hD000);
        clear_counts();
        run(820);
        for (int g = 0; g < 3; g++) chk($sformatf("restart_writes%0d", g), wr_cnt[g], 160);

        // Asynchronous reset at byte 20
        reg_write(8'hC2);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (!mon_we[0] && mon_addr[0] == 16'hC214) found = 1'b1;
            else step();
        end
        chk("reset_reached_byte20", int'(found), 1);
        reg_addr = 16'hFF46;
        #1 rst_n = 1'b0;
        #1;
        check_idle("midreset");
        for (int g = 0; g < 3; g++) chk($sformatf("midreset_rd%0d", g), mon_rd[g], 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        reg_addr = 16'h0000;
        clear_counts();
        run(900);
        for (int g = 0; g < 3; g++) chk($sformatf("after_reset_writes%0d", g), wr_cnt[g], 0);

        // Random sources, restart points and register-port noise
        for (int it = 0; it < 8; it++) begin
            int n;
            reg_write(8'($urandom));
            n = $urandom_range(1, 900);
            repeat (n) begin
                if ($urandom_range(0, 3) == 0) begin
                    reg_we = 1'b1;
                    case ($urandom_range(0, 3))
                        0: reg_addr = 16'hFF45;
                        1: reg_addr = 16'hFF47;
                        2: reg_addr = 16'hFE46;
                        default: reg_addr = 16'h7F46;
                    endcase
                end else begin
                    reg_we   = 1'b0;
                    reg_addr = ($urandom_range(0, 1) == 0) ? 16'hFF46 : 16'($urandom);
                end
                reg_wv = 8'($urandom);
                step();
            end
            reg_we   = 1'b0;
            reg_addr = 16'h0000;
        end
        run(820);
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

endmodule
